// File: rtl/conv_pkg.sv
// Shared window-generator definitions: kernel geometry, pixel type and FSM encoding.
package conv_pkg;

    localparam int DEF_CHANNEL  = 3;
    localparam int DEF_BITWIDTH = 16;
    localparam int K_WIDTH      = 3;
    localparam int K_HEIGHT     = 3;
    localparam int PORT         = K_WIDTH * K_HEIGHT * DEF_CHANNEL;

    typedef logic [DEF_CHANNEL-1:0][DEF_BITWIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixels. Read is combinational, so a write on the same
// cycle and address still returns the old contents (read-before-write).
module conv_line_buffer #(
    parameter int DEPTH = 128,
    parameter int DW    = 48,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to zero-padded 3x3xCHANNEL windows ("same" padding),
// walking a virtual (HEIGHT+1)x(WIDTH+1) raster whose extra row/column inject zeros.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int WIDTH    = 128,
    parameter int HEIGHT   = 128,
    parameter int CHANNEL  = DEF_CHANNEL,
    parameter int BITWIDTH = DEF_BITWIDTH,
    localparam int NPORT   = K_WIDTH * K_HEIGHT * CHANNEL
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CHANNEL-1:0][BITWIDTH-1:0]      i_data,
    input  logic                                  i_valid,
    output logic                                  i_ready,
    output logic [NPORT-1:0][BITWIDTH-1:0]        o_data,
    output logic [NPORT-1:0]                      o_valid,
    input  logic                                  o_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = CHANNEL * BITWIDTH;
    localparam logic [XW-1:0] X_END = XW'(WIDTH);
    localparam logic [YW-1:0] Y_END = YW'(HEIGHT);

    typedef logic [CHANNEL-1:0][BITWIDTH-1:0] pix_t;

    gen_state_e    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          steps_done;
    logic          o_vld;

    // win[ky][kx] flattens to port (ky*K_WIDTH + kx)*CHANNEL + c.
    logic [K_HEIGHT-1:0][K_WIDTH-1:0][CHANNEL-1:0][BITWIDTH-1:0] win, nwin;

    logic    real_pos, col_en, stall, step, emit, lb_we;
    pix_t    l0_q, l1_q, top, mid, bot;

    assign real_pos = (x != X_END) && (y != Y_END);
    assign col_en   = (x != X_END);
    assign stall    = o_vld && !o_ready;
    assign i_ready  = (state == RUN) && !steps_done && real_pos && !stall;
    assign step     = (state == RUN) && !steps_done &&
                      (real_pos ? (i_valid && i_ready) : !stall);
    assign emit     = step && (y != '0) && (x != '0);
    assign lb_we    = step && col_en;

    assign o_valid  = {NPORT{o_vld}};
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // L1 holds row y-1, L0 holds row y-2; each step shifts one row down.
    conv_line_buffer #(.DEPTH(WIDTH), .DW(DW), .AW(AW)) u_l0 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (x[AW-1:0]),
        .wdata (l1_q),
        .rdata (l0_q)
    );

    conv_line_buffer #(.DEPTH(WIDTH), .DW(DW), .AW(AW)) u_l1 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (x[AW-1:0]),
        .wdata (bot),
        .rdata (l1_q)
    );

    // Line buffers are never cleared; top/bottom row masking hides stale contents.
    assign top = (col_en && (y >= YW'(2))) ? l0_q : '0;
    assign mid = (col_en && (y >= YW'(1))) ? l1_q : '0;
    assign bot = real_pos ? i_data : '0;

    always_comb begin
        nwin = win;
        for (int ky = 0; ky < K_HEIGHT; ky++) begin
            nwin[ky][0] = win[ky][1];
            nwin[ky][1] = win[ky][2];
        end
        nwin[0][2] = top;
        nwin[1][2] = mid;
        nwin[2][2] = bot;
        // Columns whose source lies left of the image are zero padding.
        if (x == '0) begin
            for (int ky = 0; ky < K_HEIGHT; ky++) nwin[ky][1] = '0;
        end
        if (x <= XW'(1)) begin
            for (int ky = 0; ky < K_HEIGHT; ky++) nwin[ky][0] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            steps_done <= 1'b0;
            win        <= '0;
            o_data     <= '0;
            o_vld      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        x          <= '0;
                        y          <= '0;
                        steps_done <= 1'b0;
                        win        <= '0;
                    end
                end
                RUN: begin
                    if (step) begin
                        win <= nwin;
                        if (x == X_END) begin
                            x <= '0;
                            if (y == Y_END) steps_done <= 1'b1;
                            else            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                    if (steps_done && o_vld && o_ready) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (emit) begin
                o_data <= nwin;
                o_vld  <= 1'b1;
            end else if (o_vld && o_ready) begin
                o_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for castlab_ws_systolic_array.
- Consumes a raster pixel stream: one pixel per beat, all channels in parallel.
- Emits one zero-padded 3x3xCHANNEL window per output pixel on the array's 27-port feature input.
- Implements "same" padding, so a WIDTH x HEIGHT input yields WIDTH x HEIGHT windows.
- Uses two row line buffers plus a 3x3 window register. Supports backpressure in both directions.

Parameters:
- WIDTH, 128, feature width in pixels (debug config 4)
- HEIGHT, 128, feature height in pixels (debug config 4)
- CHANNEL, 3, channels per pixel
- BITWIDTH, 16, bits per channel sample
- K_WIDTH, 3, window width (fixed 3; other values unsupported)
- K_HEIGHT, 3, window height (fixed 3)
- PORT, K_WIDTH*K_HEIGHT*CHANNEL = 27, output ports

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins one frame
- i_data  in  [CHANNEL-1:0][BITWIDTH-1:0]  pixel, channel c at index c
- i_valid  in  1  pixel valid
- i_ready  out  1  pixel accepted when i_valid && i_ready
- o_data  out  [PORT-1:0][BITWIDTH-1:0]  window; port p = (ky*K_WIDTH + kx)*CHANNEL + c
- o_valid  out  [PORT-1:0]  all bits identical; window valid
- o_ready  in  1  window consumed when o_valid[0] && o_ready
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the last window of the frame is consumed

Behaviour:
- Reset values: i_ready=0, o_data=0, o_valid=0, busy=0, done=0. Reset mid-frame aborts the frame, returns to IDLE and discards line-buffer contents.
- FSM states and transitions:
  - IDLE: start -> RUN. Counters cleared on entry.
  - RUN: leaves on the last window consumed -> DONE.
  - DONE: one cycle; done=1; -> IDLE.
  - start outside IDLE is ignored.
- Virtual raster: counters y in 0..HEIGHT, x in 0..WIDTH, step order x-major. Total (HEIGHT+1)*(WIDTH+1) steps.
- Position type:
  - Real position: y<HEIGHT and x<WIDTH. Consumes one pixel.
  - Pad position: y==HEIGHT or x==WIDTH. Injects zeros and consumes nothing.
- stall = o_valid[0] && !o_ready.
- Step advance:
  - Real position: advances on i_valid && i_ready.
  - Pad position: advances when RUN && !stall.
  - i_ready = RUN && real position && !stall.
- Each step:
  - Reads column x of line buffers L1 (row y-1) and L0 (row y-2).
  - Shifts the window register left by one column.
  - Loads the new right column {L0, L1, current}.
  - Writes current -> L1 and L1 -> L0 at address x, read-before-write.
  - For x==WIDTH, no buffer access; the column is zero.
- Masking applied on the step data path:
  - Rows y-2<0 or y-1<0: zero.
  - Window columns with source column <0 (left pad): zero.
- Output:
  - A step with y>=1 and x>=1 registers a window centred at (y-1, x-1) into o_data with o_valid=1.
  - Latency is 1 cycle from the step to o_valid.
  - Steps with y==0 or x==0 produce no output.
- o_data and o_valid hold stable while stall.
- Window count per frame is WIDTH*HEIGHT. done fires the cycle after the final handshake; busy drops in the same cycle.
- Data is passed through bit-exact; there is no arithmetic. Counter widths are $clog2(WIDTH+1) and $clog2(HEIGHT+1).
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared package conv_pkg:
  - localparams for window geometry (K_WIDTH, K_HEIGHT, PORT)
  - pixel_t typedef: [CHANNEL-1:0][BITWIDTH-1:0]
  - FSM enum gen_state_e {IDLE, RUN, DONE}
- One sub-module, conv_line_buffer:
  - single-row memory, depth WIDTH, width CHANNEL*BITWIDTH
  - synchronous read-before-write at the same address
  - instantiated twice (L0, L1)

Test Plan:
- Debug config WIDTH=HEIGHT=4, CHANNEL=3. Stimulus: pixel(r,c) ch0 = r*4+c+1, ch1/ch2 = 0; i_valid and o_ready held high. Required response:
  - first window: port12=1, port15=2, port21=5, port24=6; ports 0..11 and all ch1/ch2 ports = 0
  - 16 windows total
  - done exactly once, 26 cycles after start
- Last window (3,3): port0=11, port12=16; ports for kx=2 or ky=2 = 0.
- o_ready toggled 1010...: o_data stable while stalled, i_ready=0 during stall, window sequence identical to scenario 1.
- i_valid deasserted for 5 random cycles mid-row: no output gaps beyond those pauses, windows correct.
- rst asserted at window 7: all outputs 0 next cycle. A new start after reset produces a correct full frame with no stale line-buffer data (use ch0 = 100 + index to detect stale values).
- start pulsed during RUN: ignored, frame count unchanged. Two back-to-back frames → two done pulses.
